// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared VLIW write-back types, widths and lane indices
package vliw_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam int LANE_ADD   = 0;
    localparam int LANE_MULHI = 1;
    localparam int LANE_MULLO = 2;
    localparam int LANE_FPA   = 3;
    localparam int LANE_FPM   = 4;
    localparam int LANE_LU    = 5;
    localparam int LANE_MEM   = 6;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_compactor.sv
// rtl/wb_compactor.sv - packs valid non-R0 lane results in lane order, limited by free space
module wb_compactor
    import vliw_pkg::*;
#(
    parameter int NUM_LANES = 7,
    parameter int CNT_W     = 5
) (
    input  logic [NUM_LANES-1:0]            valid,
    input  logic [NUM_LANES*REG_ADDR_W-1:0] rd,
    input  logic [NUM_LANES*DATA_W-1:0]     data,
    input  logic [CNT_W-1:0]                free,
    output wb_entry_t                       entries [NUM_LANES],
    output logic [CNT_W-1:0]                n_enq,
    output logic                            drop_flag
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [CNT_W-1:0] n_acc;

    always_comb begin
        n_acc     = '0;
        drop_flag = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            entries[i] = '0;
        end
        // R0 writes vanish here; only lanes past the free-space limit count as drops
        for (int i = 0; i < NUM_LANES; i++) begin
            if (valid[i] && (rd[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                if (n_acc < free) begin
                    entries[n_acc[IDX_W-1:0]].rd   = rd[i*REG_ADDR_W +: REG_ADDR_W];
                    entries[n_acc[IDX_W-1:0]].data = data[i*DATA_W +: DATA_W];
                    n_acc = n_acc + CNT_W'(1);
                end else begin
                    drop_flag = 1'b1;
                end
            end
        end
        n_enq = n_acc;
    end

endmodule

// File: rtl/vliw_wb_queue.sv
// rtl/vliw_wb_queue.sv - in-order write-back commit queue between VLIW lanes and the register file
module vliw_wb_queue
    import vliw_pkg::*;
#(
    parameter int NUM_LANES    = 7,
    parameter int DEPTH        = 16,
    parameter int WR_PORTS     = 2,
    parameter int STALL_MARGIN = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES-1:0]            res_valid,
    input  logic [NUM_LANES*REG_ADDR_W-1:0] res_rd,
    input  logic [NUM_LANES*DATA_W-1:0]     res_data,
    output logic [WR_PORTS-1:0]             wr_en,
    output logic [WR_PORTS*REG_ADDR_W-1:0]  wr_addr,
    output logic [WR_PORTS*DATA_W-1:0]      wr_data,
    output logic                            stall,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    wb_entry_t        port_e [WR_PORTS];
    wb_entry_t        enq_e  [NUM_LANES];
    logic [CNT_W-1:0] n_deq;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] free_slots;
    logic             drop;
    logic             chain;
    logic             port_ok;

    // Each port drains only if every earlier port drains and no earlier port targets the same rd
    always_comb begin
        n_deq   = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        chain   = ~rst;
        port_ok = 1'b0;
        for (int p = 0; p < WR_PORTS; p++) begin
            port_e[p] = mem_q[head_q + PTR_W'(p)];
            port_ok   = chain && (count_q > CNT_W'(p));
            for (int q = 0; q < p; q++) begin
                if (port_e[q].rd == port_e[p].rd) begin
                    port_ok = 1'b0;
                end
            end
            chain                               = port_ok;
            wr_en[p]                            = port_ok;
            wr_addr[p*REG_ADDR_W +: REG_ADDR_W] = port_e[p].rd;
            wr_data[p*DATA_W +: DATA_W]         = port_e[p].data;
            if (port_ok) begin
                n_deq = n_deq + CNT_W'(1);
            end
        end
    end

    assign free_slots = CNT_W'(DEPTH) - count_q + n_deq;

    wb_compactor #(
        .NUM_LANES (NUM_LANES),
        .CNT_W     (CNT_W)
    ) u_compactor (
        .valid     (res_valid),
        .rd        (res_rd),
        .data      (res_data),
        .free      (free_slots),
        .entries   (enq_e),
        .n_enq     (n_enq),
        .drop_flag (drop)
    );

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (CNT_W'(i) < n_enq) begin
                mem_d[tail_q + PTR_W'(i)] = enq_e[i];
            end
        end
        tail_d     = tail_q + PTR_W'(n_enq);
        head_d     = head_q + PTR_W'(n_deq);
        count_d    = count_q + n_enq - n_deq;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Stale slots are unreachable after reset because the pointers restart at zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign stall    = ~rst && ((CNT_W'(DEPTH) - count_q) < CNT_W'(STALL_MARGIN));
    assign empty    = rst || (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vliw_wb_queue.sv
// tb/tb_vliw_wb_queue.sv - scoreboard bench for vliw_wb_queue
module tb_vliw_wb_queue;
    import vliw_pkg::*;

    localparam int NL    = 7;
    localparam int DEPTH = 16;
    localparam int WP    = 2;
    localparam int SM    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NL-1:0]   res_valid;
    logic [NL*5-1:0] res_rd;
    logic [NL*32-1:0] res_data;
    logic [WP-1:0]   wr_en;
    logic [WP*5-1:0] wr_addr;
    logic [WP*32-1:0] wr_data;
    logic            stall;
    logic            empty;
    logic [4:0]      count;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    wb_entry_t   sb [$];
    bit          exp_ovf;
    logic [31:0] rf [32];
    int          max_cnt;
    bit          saw_stall;

    vliw_wb_queue #(
        .NUM_LANES    (NL),
        .DEPTH        (DEPTH),
        .WR_PORTS     (WP),
        .STALL_MARGIN (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_rd    (res_rd),
        .res_data  (res_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .stall     (stall),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        res_valid = '0;
        res_rd    = '0;
        res_data  = '0;
    endtask

    task automatic drive_lane(input int lane, input logic [4:0] rd, input logic [31:0] d);
        res_valid[lane]        = 1'b1;
        res_rd[lane*5 +: 5]    = rd;
        res_data[lane*32 +: 32] = d;
    endtask

    // Entered 1ns after a rising edge with inputs set; samples mid-cycle, then advances one cycle
    task automatic step();
        logic [WP-1:0] ee;
        wb_entry_t     e;
        #4;
        for (int p = 0; p < WP; p++) begin
            if (wr_en[p]) rf[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
        end
        if (stall) saw_stall = 1'b1;
        if (rst) begin
            check("rst_wr_en", 64'(wr_en), 64'd0);
            check("rst_stall", 64'(stall), 64'd0);
            check("rst_empty", 64'(empty), 64'd1);
        end else begin
            check("count", 64'(count), 64'(sb.size()));
            check("empty", 64'(empty), 64'(sb.size() == 0));
            check("stall", 64'(stall), 64'((DEPTH - sb.size()) < SM));
            check("overflow", 64'(overflow), 64'(exp_ovf));
            ee = '0;
            if (sb.size() >= 1) ee[0] = 1'b1;
            if (sb.size() >= 2 && sb[1].rd != sb[0].rd) ee[1] = 1'b1;
            check("wr_en", 64'(wr_en), 64'(ee));
            for (int p = 0; p < WP; p++) begin
                if (ee[p]) begin
                    e = sb.pop_front();
                    check($sformatf("wr_addr%0d", p), 64'(wr_addr[p*5 +: 5]), 64'(e.rd));
                    check($sformatf("wr_data%0d", p), 64'(wr_data[p*32 +: 32]), 64'(e.data));
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (res_valid[i] && res_rd[i*5 +: 5] != 5'd0) begin
                    if (sb.size() < DEPTH) begin
                        e.rd   = res_rd[i*5 +: 5];
                        e.data = res_data[i*32 +: 32];
                        sb.push_back(e);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
        end
        if (rst) begin
            sb.delete();
            exp_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst       = 1'b1;
        exp_ovf   = 1'b0;
        saw_stall = 1'b0;
        max_cnt   = 0;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        @(posedge clk);
        #1;

        step();
        step();
        rst = 1'b0;
        step();
        step();

        drive_lane(LANE_ADD, 5'd5, 32'h0000_000A);
        step();
        clear_inputs();
        repeat (2) step();

        drive_lane(LANE_MULHI, 5'd3, 32'h11);
        drive_lane(LANE_MULLO, 5'd4, 32'h22);
        drive_lane(LANE_LU,    5'd7, 32'h33);
        step();
        clear_inputs();
        repeat (3) step();

        drive_lane(LANE_ADD, 5'd9, 32'hAA);
        drive_lane(LANE_MEM, 5'd9, 32'hBB);
        step();
        clear_inputs();
        repeat (3) step();
        check("rf_r9", 64'(rf[9]), 64'hBB);

        drive_lane(LANE_FPA, 5'd0, 32'hFFFF_FFFF);
        step();
        clear_inputs();
        repeat (2) step();

        saw_stall = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NL; i++) drive_lane(i, 5'(i + 1), 32'(c * 16 + i));
            step();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        clear_inputs();
        check("fill_max_count", 64'(max_cnt), 64'd16);
        check("fill_overflow", 64'(overflow), 64'd1);
        check("fill_saw_stall", 64'(saw_stall), 64'd1);
        repeat (10) step();
        check("ovf_sticky", 64'(overflow), 64'd1);

        drive_lane(LANE_FPM, 5'd12, 32'hDEAD_BEEF);
        rst = 1'b1;
        step();
        clear_inputs();
        rst = 1'b0;
        step();
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_ovf", 64'(overflow), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
